id_ex_pipe: RTL
===============

// Module: id_ex_pipe
// PURPOSE
//  ID->EX pipeline register for the 5-stage RV32I core. Captures the decoded instruction fields and the
//  Controller's control bundle each cycle and presents them to the execute stage. Detects load-use
//  hazards and inserts a one-cycle bubble while stalling PC/IF-ID. Applies branch/jump flushes.
//  Also qualifies reg_wr: stores and branches never write the register file.
// PARAMETERS
//  XLEN      32   datapath width (pc, rs data, imm)
//  REG_AW    5    register-address width
// PORTS
//  clk            in   1      core clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  inst_i         in   32     ID-stage instruction (rd/rs1/rs2/opcode sliced internally)
//  pc_i           in   XLEN   ID-stage PC
//  rdata1_i       in   XLEN   register-file read data, rs1
//  rdata2_i       in   XLEN   register-file read data, rs2
//  imm_i          in   XLEN   immediate-generator output
//  ctrl_i         in   ctrl_t Controller bundle {alu_op[3:0],reg_wr,select_b,rd_en,wb_sel[1:0],write_enable,br_type[1:0],sel_A}
//  id_valid_i     in   1      ID stage holds a real instruction
//  stall_i        in   1      external hold (e.g. memory not ready): freeze all EX registers
//  flush_i        in   1      taken branch / jump resolved in EX: kill the ID instruction
//  ctrl_o         out  ctrl_t registered control bundle for EX
//  pc_o, rdata1_o, rdata2_o, imm_o  out XLEN  registered datapath values
//  rd_o, rs1_o, rs2_o               out REG_AW registered register addresses
//  ex_valid_o     out  1      EX holds a real instruction
//  hz_stall_o     out  1      combinational: hold PC and IF/ID this cycle (load-use)
// BEHAVIOUR
//  - Reset: every output register 0; ctrl_o = all-zero bundle (alu_add, no write, no branch); ex_valid_o=0.
//  - Latency: 1 cycle, ID values visible on outputs the cycle after capture.
//  - Per-edge priority: rst > flush_i > stall_i > load-use bubble > normal advance.
//    flush_i : load bubble; also wins over hz_stall_o (the killed instruction must not stall the front end).
//    stall_i : hold every register; hz_stall_o still computed but front end is already held.
//    bubble  : ex_valid_o<=0, reg_wr/rd_en/write_enable<=0, br_type<=2'b00. Datapath fields don't care, driven 0.
//    advance : capture all inputs; ex_valid_o<=id_valid_i.
//  - Load-use: hz_stall_o = ex_valid_o & ctrl_o.rd_en & (rd_o!=0) & id_valid_i & ~flush_i &
//      ((uses_rs1 & rs1==rd_o) | (uses_rs2 & rs2==rd_o)).
//    uses_rs1 = opcode not in {op_ui, op_a, op_j}. uses_rs2 = opcode in {op_r, op_s, op_b}.
//    Exactly one bubble per load-use pair. The next cycle the load has left EX, so hz_stall_o deasserts.
//  - reg_wr qualification on capture: reg_wr_o = ctrl_i.reg_wr & (opcode not in {op_s, op_b}) & (rd != 0).
//  - Unknown opcode with id_valid_i=1: captured as a bubble (no writes) and ex_valid_o=0.
//  - Back-to-back loads feeding each other: each pair handled independently, one bubble each.
//  - rst asserted mid-stall or mid-bubble: outputs return to reset values next edge and no state is carried over.
//  - sel_A=x from the Controller (LUI): registered as 0.
// STRUCTURE
//  - Shared package (DEFS.svh): ctrl_t packed struct; CTRL_NOP constant; existing type_opcode and ALU-op enums.
//    Add uses_rs1()/uses_rs2() functions there so the forwarding unit reuses them.
//  - One sub-module: load_use_detect (pure combinational, produces hz_stall_o). The register bank stays in id_ex_pipe.
// TESTING
//  - Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, ex_valid_o=0, hz_stall_o=0.
//  - Advance: ADD x3,x1,x2 at pc=0x40 -> next cycle pc_o=0x40, rd_o=3, ctrl_o.alu_op=alu_add, reg_wr=1, ex_valid_o=1.
//  - Load-use: LW x5,0(x1) then ADD x6,x5,x2 -> hz_stall_o=1 for exactly 1 cycle, one bubble, then ADD captured with rs1_o=5.
//    Repeat with rd=x0 -> no stall.
//  - No false hazard: LW x5 then LUI x5,0x1 -> hz_stall_o=0. LW x5 then SW x5,0(x7) -> stall, since rs2 is used.
//  - Flush vs stall: flush_i=1 and hz_stall_o condition in the same cycle -> bubble loaded, hz_stall_o=0.
//    flush_i=1 with stall_i=1 -> bubble.
//  - Qualification/hold: SW and BEQ captured with reg_wr=0. stall_i=1 for 3 cycles -> all outputs unchanged.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared decode definitions for the RV32I core.
//   type_opcode : base-opcode encodings (inst[6:0])
//   alu_op_t    : ALU operation select
//   ctrl_t      : Controller bundle carried down the pipe
//   CTRL_NOP    : all-zero bundle (alu_add, no writes, no branch)
//   uses_rs1/uses_rs2/may_write_rd/is_known_op : opcode classification helpers,
//   shared with the forwarding unit.
package id_ex_pipe_pkg;

  typedef enum logic [6:0] {
    op_r  = 7'b0110011,
    op_i  = 7'b0010011,
    op_l  = 7'b0000011,
    op_s  = 7'b0100011,
    op_b  = 7'b1100011,
    op_ui = 7'b0110111,
    op_a  = 7'b0010111,
    op_j  = 7'b1101111,
    op_ji = 7'b1100111
  } type_opcode;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_slt  = 4'd3,
    alu_sltu = 4'd4,
    alu_xor  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_or   = 4'd8,
    alu_and  = 4'd9,
    alu_lui  = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        reg_wr;
    logic        select_b;
    logic        rd_en;
    logic [1:0]  wb_sel;
    logic        write_enable;
    logic [1:0]  br_type;
    logic        sel_A;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      op_r, op_i, op_l, op_s, op_b, op_ui, op_a, op_j, op_ji: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {op_ui, op_a, op_j});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {op_r, op_s, op_b};
  endfunction

  // Stores and branches have no destination register.
  function automatic logic may_write_rd(input logic [6:0] op);
    return !(op inside {op_s, op_b});
  endfunction

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
//   ex_valid_i/ex_rd_en_i/ex_rd_i : instruction currently in EX (rd_en = load)
//   id_valid_i/id_opcode_i/id_rs1_i/id_rs2_i : instruction currently in ID
//   flush_i   : ID instruction is being killed, so it must not stall
//   hz_stall_o: hold PC and IF/ID this cycle
module load_use_detect
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_rd_en_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              hz_stall_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = uses_rs1(id_opcode_i) & (id_rs1_i == ex_rd_i);
    rs2_hit    = uses_rs2(id_opcode_i) & (id_rs2_i == ex_rd_i);
    hz_stall_o = ex_valid_i & ex_rd_en_i & (ex_rd_i != '0) & id_valid_i & ~flush_i
               & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with load-use bubble insertion.
//   inst_i/pc_i/rdata*_i/imm_i/ctrl_i/id_valid_i : ID-stage values
//   stall_i : freeze all EX registers
//   flush_i : kill the ID instruction (bubble), overrides stall_i and hz_stall_o
//   ctrl_o, pc_o, rdata1_o, rdata2_o, imm_o, rd_o, rs1_o, rs2_o, ex_valid_o : EX-stage values
//   hz_stall_o : combinational load-use stall for PC and IF/ID
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rdata1_i,
  input  logic [XLEN-1:0]   rdata2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  ctrl_t             ctrl_i,
  input  logic              id_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output ctrl_t             ctrl_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic              ex_valid_o,
  output logic              hz_stall_o
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
  logic              hz_stall;
  logic              kill;
  ctrl_t             ctrl_cap;

  ctrl_t             ctrl_q, ctrl_d;
  logic [XLEN-1:0]   pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic              ex_valid_q, ex_valid_d;

  // funct3/funct7 are decoded upstream; not needed here.
  logic unused_inst;
  assign unused_inst = ^{inst_i[31:25], inst_i[14:12]};

  assign opcode = inst_i[6:0];
  assign id_rd  = inst_i[11:7];
  assign id_rs1 = inst_i[19:15];
  assign id_rs2 = inst_i[24:20];

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .ex_valid_i  (ex_valid_q),
    .ex_rd_en_i  (ctrl_q.rd_en),
    .ex_rd_i     (rd_q),
    .id_valid_i  (id_valid_i),
    .flush_i     (flush_i),
    .id_opcode_i (opcode),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .hz_stall_o  (hz_stall)
  );

  always_comb begin
    ctrl_cap        = ctrl_i;
    ctrl_cap.reg_wr = ctrl_i.reg_wr & may_write_rd(opcode) & (id_rd != '0);
    // LUI leaves sel_A undriven in the Controller; pin it low.
    if (opcode == op_ui) ctrl_cap.sel_A = 1'b0;

    // Flush overrides stall; a load-use bubble or an illegal opcode only
    // takes effect when the pipe is allowed to advance.
    kill = flush_i | (~stall_i & (hz_stall | (id_valid_i & ~is_known_op(opcode))));

    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    ex_valid_d = ex_valid_q;

    if (kill) begin
      ctrl_d     = CTRL_NOP;
      pc_d       = '0;
      rdata1_d   = '0;
      rdata2_d   = '0;
      imm_d      = '0;
      rd_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      ex_valid_d = 1'b0;
    end else if (!stall_i) begin
      ctrl_d     = ctrl_cap;
      pc_d       = pc_i;
      rdata1_d   = rdata1_i;
      rdata2_d   = rdata2_i;
      imm_d      = imm_i;
      rd_d       = id_rd;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      ex_valid_d = id_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_NOP;
      pc_q       <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign pc_o       = pc_q;
  assign rdata1_o   = rdata1_q;
  assign rdata2_o   = rdata2_q;
  assign imm_o      = imm_q;
  assign rd_o       = rd_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;
  assign ex_valid_o = ex_valid_q;
  assign hz_stall_o = hz_stall;

endmodule
